// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-granular round-robin scheduler sharing one uart_tx between NUM_REQ byte streams.
// Optional build macro UART_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module uart_tx_sched #(
    parameter int NUM_REQ        = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 200,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 parity_cfg,
    input  logic                 err_clr,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 parity_type,
    input  logic                 tx_done,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_e;

    state_e               state_q;
    logic [GW-1:0]        rr_ptr_q;
    logic [GW-1:0]        grant_q;
    logic                 busy_q;
    logic                 start_q;
    logic [7:0]           data_q;
    logic                 par_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 err_q;
    logic                 last_q;
    logic                 rel_q;
    logic [TW-1:0]        tcnt_q;
    logic [GCW-1:0]       gcnt_q;
    logic                 found_d;
    logic [GW-1:0]        pick_d;

    // first pending requester at or after the round-robin pointer, wrapping past the top index
    always_comb begin
        int idx;
        idx     = 0;
        found_d = 1'b0;
        pick_d  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found_d && req[idx]) begin
                found_d = 1'b1;
                pick_d  = GW'(idx);
            end
        end
    end

    // scheduler FSM: grant, load one byte, wait for the frame, enforce the gap, then lock or release
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
            par_q    <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
            rel_q    <= 1'b0;
            tcnt_q   <= '0;
            gcnt_q   <= '0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            if (err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= pick_d;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    start_q <= 1'b1;
                    data_q  <= req_data[8*grant_q +: 8];
                    par_q   <= parity_cfg;
                    ack_q   <= NUM_REQ'(1) << grant_q;
                    last_q  <= req_last[grant_q];
                    rel_q   <= 1'b0;
                    tcnt_q  <= '0;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        gcnt_q  <= '0;
                        state_q <= GAP;
                    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        rel_q   <= 1'b1;
                        gcnt_q  <= '0;
                        state_q <= GAP;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt_q != GCW'(GAP_CYCLES - 1)) begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end else if (last_q || rel_q || !req[grant_q]) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef UART_SCHED_FIXED_PRIO_EN
                        rr_ptr_q <= '0;
`else
                        rr_ptr_q <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack     = ack_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign parity_type = par_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx serializer (8N1+parity, 11-bit frame, 14 clk_3125 cycles per bit) between NUM_REQ byte-stream requesters, e.g. color-result reporter, status/heartbeat, debug echo.
- Grants at packet granularity: a requester keeps the UART until it marks a byte last, drops its request, or a frame times out.
- Drives uart_tx tx_start/data/parity_type and consumes tx_done.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles inserted after each tx_done before the next tx_start (>=1).
- TIMEOUT_CYCLES, 200, max cycles in WAIT_DONE without tx_done (nominal frame is 154).

Ports:
- clk_3125 input 1: 3.125 MHz system clock.
- rst_n input 1: asynchronous active-low reset.
- req input NUM_REQ: per-requester "byte available", level; held until acked.
- req_data input 8*NUM_REQ: byte for requester i on bits [8i+7:8i]; stable while req[i] is high.
- req_last input NUM_REQ: byte currently offered is the final byte of its packet.
- req_ack output NUM_REQ: one-cycle pulse; the offered byte of requester i is consumed.
- parity_cfg input 1: 0 = even, 1 = odd; sampled per frame.
- err_clr input 1: clears err_timeout.
- tx_start output 1: one-cycle start pulse to uart_tx.
- tx_data output 8: byte to uart_tx, held stable from tx_start until tx_done.
- parity_type output 1: to uart_tx, latched with tx_data.
- tx_done input 1: one-cycle pulse from uart_tx at end of stop bit.
- grant_id output GW (GW = max(1, clog2(NUM_REQ))): current owner, valid while busy.
- busy output 1: high from grant until return to IDLE.
- err_timeout output 1: sticky timeout flag.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; rr_ptr=0; outputs tx_start=0, tx_data=0, parity_type=0, req_ack=0, grant_id=0, busy=0, err_timeout=0; counters cleared. A frame in flight is abandoned. The serializer is expected to be reset by the same rst_n.
- FSM states: IDLE, LOAD, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is high, select the first set bit at or after rr_ptr (wrapping).
  - Register grant_id, set busy=1, go to LOAD.
  - With no request, stay in IDLE.
- LOAD (exactly 1 cycle):
  - tx_start=1; tx_data=req_data[grant]; parity_type=parity_cfg.
  - req_ack[grant]=1; capture last_q=req_last[grant]; clear timeout counter; go to WAIT_DONE.
  - Latency: req rising in IDLE gives tx_start 2 cycles later.
- WAIT_DONE:
  - Count cycles. On tx_done, go to GAP.
  - If the count reaches TIMEOUT_CYCLES first, set err_timeout=1, force release (rel=1), go to GAP.
  - tx_done outside WAIT_DONE is ignored.
- GAP: wait GAP_CYCLES cycles, then:
  - If last_q or rel: rr_ptr=grant+1 (wrapping at NUM_REQ), busy=0, go to IDLE.
  - Else if req[grant] is high: go to LOAD with the same grant (packet lock).
  - Else (requester dropped mid-packet): release as above.
- Round-robin: after a release, the released requester has lowest priority. No requester waits longer than NUM_REQ-1 packets.
- req_ack never pulses for a non-granted index and never pulses twice per frame.
- err_clr and a timeout in the same cycle: the set wins.
- Changes to parity_cfg mid-frame take effect at the next LOAD only.

Optional Feature:
- UART_SCHED_FIXED_PRIO_EN: when defined, IDLE picks the lowest-index set req bit, rr_ptr is unused and held at 0, and packet lock still applies.
- When undefined, arbitration is round-robin as above.

Test Plan:
- Single byte: req[0]=1, req_data=8'hA5, req_last=1, parity_cfg=0 → tx_start 2 cycles after req; tx_data=A5; parity_type=0; req_ack[0] pulses in the same cycle as tx_start; busy falls GAP_CYCLES+1 cycles after tx_done.
- Packet lock: req[1] sends 3 bytes 11,22,33 (last on 33) while req[0] and req[2] are held high → three consecutive frames from requester 1; next grant is 2, then 0.
- Round-robin fairness: all req high, every byte last → grant_id sequence 0,1,2,0,1,2. With UART_SCHED_FIXED_PRIO_EN defined → 0,0,0 while req[0] stays high.
- Timeout: stub holds tx_done low → err_timeout=1 exactly TIMEOUT_CYCLES=200 cycles after tx_start, grant released, next requester served; err_clr clears the flag.
- Mid-packet drop: requester 2 last=0, then deasserts req during WAIT_DONE → after GAP, busy=0 and rr_ptr=0. Async reset during WAIT_DONE → all outputs at reset values immediately, with no tx_start after reset release until a new req.
- Integration with real uart_tx: 10 bytes from data_tx.txt via requester 0 → serialized tx line matches the expected start/data/parity/stop bits at 14 cycles per bit, with parity even.
